// File: rtl/hvgen_pkg.sv
// Shared definitions for the parametrised video timing generator:
// default timing set, the registered timing bundle and a modular add helper.
package hvgen_pkg;

  // Default timing set (384x263 arcade raster)
  localparam int DEF_H_TOTAL   = 384;
  localparam int DEF_H_ACT_BEG = 24;
  localparam int DEF_H_ACT_END = 280;
  localparam int DEF_V_TOTAL   = 263;
  localparam int DEF_V_ACT     = 224;
  localparam int DEF_HS_START  = 312;
  localparam int DEF_HS_WIDTH  = 32;
  localparam int DEF_VS_START  = 234;
  localparam int DEF_VS_WIDTH  = 3;
  localparam int DEF_OFFS_W    = 5;
  localparam int DEF_H_STEP    = 2;
  localparam int DEF_V_STEP    = 1;
  localparam int DEF_RGB_W     = 12;
  localparam int DEF_POS_W     = 9;

  // Blanking/sync bundle, registered as one unit in the top
  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hs_n;
    logic vs_n;
    logic de;
  } hvgen_timing_t;

  // (base + offs*step) mod total. base < total and |offs*step| < total,
  // so one correction in either direction is always enough.
  function automatic int wrap_add(input int base, input int offs,
                                  input int step, input int total);
    int r;
    r = base + (offs * step);
    if (r < 0) begin
      r = r + total;
    end else if (r >= total) begin
      r = r - total;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/hvgen_window.sv
// Wrap-aware window comparator: o_in_win is high when i_cnt lies in
// [i_beg, i_beg+WIDTH) taken modulo TOTAL. i_beg must be below TOTAL.
module hvgen_window #(
  parameter int CNT_W = 9,
  parameter int TOTAL = 384,
  parameter int WIDTH = 32
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_beg,
  output logic             o_in_win
);

  // One extra bit so beg+WIDTH never overflows before the wrap test
  localparam int EW = CNT_W + 1;
  localparam logic [EW-1:0] L_WIDTH = EW'(WIDTH);
  localparam logic [EW-1:0] L_TOTAL = EW'(TOTAL);

  logic [EW-1:0] w_end;
  logic [EW-1:0] w_cnt;

  // Window test: plain range when the end stays inside the total, otherwise
  // the window is split into a tail [beg, TOTAL) and a head [0, end-TOTAL)
  always_comb begin
    w_cnt = {1'b0, i_cnt};
    w_end = {1'b0, i_beg} + L_WIDTH;
    if (w_end <= L_TOTAL) begin
      o_in_win = (i_cnt >= i_beg) && (w_cnt < w_end);
    end else begin
      o_in_win = (i_cnt >= i_beg) || (w_cnt < (w_end - L_TOTAL));
    end
  end

endmodule

// File: rtl/hvgen_param.sv
// Parametrised video timing generator running on clk_sys with a pixel
// clock-enable. Sync windows are moved by signed offsets that are latched
// at frame start; counters are never disturbed by the offsets.
module hvgen_param
  import hvgen_pkg::*;
#(
  parameter int H_TOTAL   = DEF_H_TOTAL,
  parameter int H_ACT_BEG = DEF_H_ACT_BEG,
  parameter int H_ACT_END = DEF_H_ACT_END,
  parameter int V_TOTAL   = DEF_V_TOTAL,
  parameter int V_ACT     = DEF_V_ACT,
  parameter int HS_START  = DEF_HS_START,
  parameter int HS_WIDTH  = DEF_HS_WIDTH,
  parameter int VS_START  = DEF_VS_START,
  parameter int VS_WIDTH  = DEF_VS_WIDTH,
  parameter int OFFS_W    = DEF_OFFS_W,
  parameter int H_STEP    = DEF_H_STEP,
  parameter int V_STEP    = DEF_V_STEP,
  parameter int RGB_W     = DEF_RGB_W,
  parameter int POS_W     = DEF_POS_W
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ce_pix,
  input  logic signed [OFFS_W-1:0] h_offs,
  input  logic signed [OFFS_W-1:0] v_offs,
  input  logic [RGB_W-1:0]         rgb_in,
  output logic [POS_W-1:0]         hpos,
  output logic [POS_W-1:0]         vpos,
  output logic                     hblank,
  output logic                     vblank,
  output logic                     hs_n,
  output logic                     vs_n,
  output logic                     de,
  output logic                     line_start,
  output logic                     frame_start,
  output logic [7:0]               frame_cnt,
  output logic [RGB_W-1:0]         rgb_out
);

  // Elaboration-time sanity checks on the timing set
  if (!((H_ACT_BEG < H_ACT_END) && (H_ACT_END <= H_TOTAL))) begin : g_bad_hact
    $error("hvgen_param: need H_ACT_BEG < H_ACT_END <= H_TOTAL");
  end
  if (!(V_ACT < V_TOTAL)) begin : g_bad_vact
    $error("hvgen_param: need V_ACT < V_TOTAL");
  end
  if (!(HS_WIDTH < H_TOTAL)) begin : g_bad_hsw
    $error("hvgen_param: need HS_WIDTH < H_TOTAL");
  end
  if (!(VS_WIDTH < V_TOTAL)) begin : g_bad_vsw
    $error("hvgen_param: need VS_WIDTH < V_TOTAL");
  end
  if (!(((2 ** POS_W) >= H_TOTAL) && ((2 ** POS_W) >= V_TOTAL))) begin : g_bad_posw
    $error("hvgen_param: POS_W too narrow for the totals");
  end
  if (!(((2 ** (OFFS_W - 1)) * H_STEP) < H_TOTAL)) begin : g_bad_hoffs
    $error("hvgen_param: horizontal offset range exceeds H_TOTAL");
  end
  if (!(((2 ** (OFFS_W - 1)) * V_STEP) < V_TOTAL)) begin : g_bad_voffs
    $error("hvgen_param: vertical offset range exceeds V_TOTAL");
  end
  if (!((HS_START < H_TOTAL) && (VS_START < V_TOTAL))) begin : g_bad_sstart
    $error("hvgen_param: sync start must lie inside the total");
  end

  localparam logic [POS_W-1:0] L_H_LAST    = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] L_V_LAST    = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] L_HACT_BEG  = POS_W'(H_ACT_BEG);
  localparam logic [POS_W-1:0] L_ZERO      = POS_W'(0);
  localparam logic [POS_W-1:0] L_ONE       = POS_W'(1);
  localparam hvgen_timing_t    L_TIM_RST   = '{hblank: 1'b1, vblank: 1'b1,
                                               hs_n: 1'b1, vs_n: 1'b1, de: 1'b0};

  // Registered state
  logic                     r_started;   // low until the first ce_pix after reset
  logic [POS_W-1:0]         r_hcnt;
  logic [POS_W-1:0]         r_vcnt;
  logic signed [OFFS_W-1:0] r_h_sh;
  logic signed [OFFS_W-1:0] r_v_sh;
  logic [POS_W-1:0]         r_hpos;
  logic [POS_W-1:0]         r_vpos;
  hvgen_timing_t            r_tim;
  logic                     r_line_start;
  logic                     r_frame_start;
  logic [7:0]               r_frame_cnt;
  logic [RGB_W-1:0]         r_rgb;

  // Next-state wires
  logic [POS_W-1:0]         w_hcnt_nxt;
  logic [POS_W-1:0]         w_vcnt_nxt;
  logic                     w_line_wrap;
  logic                     w_frame_wrap;
  logic signed [OFFS_W-1:0] w_h_sh_nxt;
  logic signed [OFFS_W-1:0] w_v_sh_nxt;
  logic [POS_W-1:0]         w_hs_beg;
  logic [POS_W-1:0]         w_vs_beg;
  logic                     w_hs_in;
  logic                     w_vs_in;
  logic                     w_hact;
  logic                     w_vact;
  hvgen_timing_t            w_tim_nxt;

  // Counter advance; the first enable after reset presents (0,0) without
  // moving so the new frame starts cleanly from the origin
  always_comb begin
    w_hcnt_nxt   = r_hcnt;
    w_vcnt_nxt   = r_vcnt;
    w_line_wrap  = 1'b0;
    w_frame_wrap = 1'b0;
    if (!r_started) begin
      w_hcnt_nxt   = L_ZERO;
      w_vcnt_nxt   = L_ZERO;
      w_line_wrap  = 1'b1;
      w_frame_wrap = 1'b1;
    end else if (r_hcnt == L_H_LAST) begin
      w_hcnt_nxt  = L_ZERO;
      w_line_wrap = 1'b1;
      if (r_vcnt == L_V_LAST) begin
        w_vcnt_nxt   = L_ZERO;
        w_frame_wrap = 1'b1;
      end else begin
        w_vcnt_nxt = r_vcnt + L_ONE;
      end
    end else begin
      w_hcnt_nxt = r_hcnt + L_ONE;
    end
  end

  // Shadow offsets only change when entering (0,0); effective sync starts
  // are derived from the shadows that will be in force for the new position
  always_comb begin
    if (w_frame_wrap) begin
      w_h_sh_nxt = h_offs;
      w_v_sh_nxt = v_offs;
    end else begin
      w_h_sh_nxt = r_h_sh;
      w_v_sh_nxt = r_v_sh;
    end
    w_hs_beg = POS_W'(wrap_add(HS_START, int'(w_h_sh_nxt), H_STEP, H_TOTAL));
    w_vs_beg = POS_W'(wrap_add(VS_START, int'(w_v_sh_nxt), V_STEP, V_TOTAL));
  end

  hvgen_window #(.CNT_W(POS_W), .TOTAL(H_TOTAL), .WIDTH(HS_WIDTH)) u_hsync (
    .i_cnt    (w_hcnt_nxt),
    .i_beg    (w_hs_beg),
    .o_in_win (w_hs_in)
  );

  hvgen_window #(.CNT_W(POS_W), .TOTAL(V_TOTAL), .WIDTH(VS_WIDTH)) u_vsync (
    .i_cnt    (w_vcnt_nxt),
    .i_beg    (w_vs_beg),
    .o_in_win (w_vs_in)
  );

  hvgen_window #(.CNT_W(POS_W), .TOTAL(H_TOTAL), .WIDTH(H_ACT_END - H_ACT_BEG)) u_hact (
    .i_cnt    (w_hcnt_nxt),
    .i_beg    (L_HACT_BEG),
    .o_in_win (w_hact)
  );

  hvgen_window #(.CNT_W(POS_W), .TOTAL(V_TOTAL), .WIDTH(V_ACT)) u_vact (
    .i_cnt    (w_vcnt_nxt),
    .i_beg    (L_ZERO),
    .o_in_win (w_vact)
  );

  // Assemble the timing bundle for the upcoming counter position
  always_comb begin
    w_tim_nxt.hblank = ~w_hact;
    w_tim_nxt.vblank = ~w_vact;
    w_tim_nxt.hs_n   = ~w_hs_in;
    w_tim_nxt.vs_n   = ~w_vs_in;
    w_tim_nxt.de     = w_hact & w_vact;
  end

  // Counters, shadows and position outputs; hold while ce_pix is low
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_started <= 1'b0;
      r_hcnt    <= L_ZERO;
      r_vcnt    <= L_ZERO;
      r_h_sh    <= '0;
      r_v_sh    <= '0;
      r_hpos    <= L_ZERO - L_HACT_BEG;
      r_vpos    <= L_ZERO;
    end else if (ce_pix) begin
      r_started <= 1'b1;
      r_hcnt    <= w_hcnt_nxt;
      r_vcnt    <= w_vcnt_nxt;
      r_h_sh    <= w_h_sh_nxt;
      r_v_sh    <= w_v_sh_nxt;
      r_hpos    <= w_hcnt_nxt - L_HACT_BEG;
      r_vpos    <= w_vcnt_nxt;
    end else begin
      r_started <= r_started;
      r_hcnt    <= r_hcnt;
      r_vcnt    <= r_vcnt;
      r_h_sh    <= r_h_sh;
      r_v_sh    <= r_v_sh;
      r_hpos    <= r_hpos;
      r_vpos    <= r_vpos;
    end
  end

  // Timing bundle, blank-gated pixel, strobes and frame counter
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_tim         <= L_TIM_RST;
      r_rgb         <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else if (ce_pix) begin
      r_tim         <= w_tim_nxt;
      r_rgb         <= w_tim_nxt.de ? rgb_in : '0;
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
      // The restart after reset is frame 0, only real wraps count
      if (w_frame_wrap && r_started) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end else begin
      r_tim         <= r_tim;
      r_rgb         <= r_rgb;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= r_frame_cnt;
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign hblank      = r_tim.hblank;
  assign vblank      = r_tim.vblank;
  assign hs_n        = r_tim.hs_n;
  assign vs_n        = r_tim.vs_n;
  assign de          = r_tim.de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
  assign rgb_out     = r_rgb;

endmodule

// File: doc/hvgen_param.md
Name: hvgen_param

Overview:
- Parametrised video timing generator: successor to the fixed 384x263 arcade timing block.
- Horizontal and vertical totals, active window, sync position/width and RGB width are parameters; runs on `clk_sys` with a pixel clock-enable instead of a derived pixel clock.
- Adds signed H/V sync offsets, double-buffered at frame start so mid-frame menu changes never tear sync.
- Adds line-start/frame-start strobes and a frame counter.
- Sits between the game core (consumes `hpos`/`vpos`, supplies `rgb_in`) and `arcade_fx`/scandoubler.

Parameters:
- H_TOTAL, 384, pixel clocks per line
- H_ACT_BEG, 24, first active pixel (`hcnt` value)
- H_ACT_END, 280, first blanked pixel after active
- V_TOTAL, 263, lines per frame
- V_ACT, 224, active lines (`vcnt` 0..V_ACT-1)
- HS_START, 312, nominal hsync start (`hcnt`)
- HS_WIDTH, 32, hsync width in pixels
- VS_START, 234, nominal vsync start line
- VS_WIDTH, 3, vsync width in lines
- OFFS_W, 5, width of signed offset inputs
- H_STEP, 2, pixels per horizontal offset unit
- V_STEP, 1, lines per vertical offset unit
- RGB_W, 12, pixel bus width
- POS_W, 9, width of `hpos`/`vpos`

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- ce_pix  in  1  pixel clock enable; all state advances only when high
- h_offs  in  OFFS_W  signed horizontal sync offset, two's complement
- v_offs  in  OFFS_W  signed vertical sync offset, two's complement
- rgb_in  in  RGB_W  pixel from core
- hpos  out  POS_W  `hcnt`-H_ACT_BEG, modulo 2^POS_W
- vpos  out  POS_W  `vcnt`
- hblank  out  1  horizontal blank
- vblank  out  1  vertical blank
- hs_n  out  1  horizontal sync, active low
- vs_n  out  1  vertical sync, active low
- de  out  1  ~(hblank|vblank)
- line_start  out  1  one-`ce_pix` strobe at `hcnt`==0
- frame_start  out  1  one-`ce_pix` strobe at `hcnt`==0, `vcnt`==0
- frame_cnt  out  8  frames since reset, wraps 255->0
- rgb_out  out  RGB_W  blank-gated registered pixel

Behaviour:
- Reset (`reset_n`=0 at a `clk_sys` edge, regardless of `ce_pix`):
  - `hcnt`=0, `vcnt`=0, shadows=0, `frame_cnt`=0
  - `hblank`=1, `vblank`=1, `hs_n`=1, `vs_n`=1, `de`=0, strobes=0, `rgb_out`=0
- Reset mid-frame restarts the frame at 0,0 on the first `ce_pix` after release; no partial sync pulse survives reset.
- Counters, on `ce_pix`:
  - `hcnt` 0..H_TOTAL-1, then wraps to 0.
  - `vcnt` increments when `hcnt` wraps; `vcnt` V_TOTAL-1 wraps to 0.
  - There are no counter jumps. Offsets move the sync windows, never the counters, so line and frame length stay constant for any offset.
- Shadow offsets:
  - `h_sh`/`v_sh` load `h_offs`/`v_offs` on the `ce_pix` where the counters wrap to (0,0).
  - Input changes at any other time take effect from the next frame.
- Effective sync starts, computed in widths large enough to avoid overflow, then reduced modulo the total:
  - `hs_beg` = (HS_START + `h_sh`*H_STEP) mod H_TOTAL
  - `vs_beg` = (VS_START + `v_sh`*V_STEP) mod V_TOTAL
  - Negative intermediate values add the total once. Offsets are bounded by OFFS_W, so a single correction suffices; elaboration asserts 2^(OFFS_W-1)*STEP < total.
- Windows, all wrap-aware modulo the total:
  - `hs_n`=0 for `hcnt` in [`hs_beg`, `hs_beg`+HS_WIDTH).
  - `vs_n`=0 for `vcnt` in [`vs_beg`, `vs_beg`+VS_WIDTH). `vs_n` changes only with `hcnt`==0, i.e. line-aligned.
  - `hblank`=1 unless H_ACT_BEG <= `hcnt` < H_ACT_END.
  - `vblank`=1 iff `vcnt` >= V_ACT.
- Latency and registering:
  - All outputs are registered and update on the same `ce_pix` that moves the counters, so they reflect the new counter values one `clk_sys` later.
  - `rgb_out` = (`hblank`|`vblank`) ? 0 : `rgb_in`, sampled on `ce_pix` using the blank state being output that cycle.
- Strobes:
  - `line_start`/`frame_start` assert for exactly one `clk_sys` cycle when the corresponding state is entered, then clear.
  - `frame_cnt` increments together with `frame_start`.
- `ce_pix` low: every register holds, and strobes clear after one cycle.
- Elaboration checks:
  - H_ACT_BEG < H_ACT_END <= H_TOTAL
  - V_ACT < V_TOTAL
  - HS_WIDTH < H_TOTAL
  - VS_WIDTH < V_TOTAL
  - 2^POS_W >= max(H_TOTAL, V_TOTAL)

Decomposition:
- Package `hvgen_pkg`:
  - localparams for the default timing set (H_TOTAL/V_TOTAL/active/sync defaults)
  - a `hvgen_timing_t` struct (`hblank`, `vblank`, `hs_n`, `vs_n`, `de`)
  - function `wrap_add(base, offs, step, total)` returning the modulo result
- Sub-module `hvgen_window`: wrap-aware "counter in [beg, beg+width) mod total" comparator, instantiated for hsync, vsync, H-active and V-active.

Test Plan:
- Defaults, offsets 0, run 2 frames:
  - 384 `ce_pix` per line, 263 lines per frame
  - `hs_n` low at `hcnt` 312..343; `vs_n` low on lines 234..236
  - `de` high for exactly 256x224 pixels; `frame_cnt`=2
- `h_offs`=+15 (H_STEP 2): `hs_beg`=342, `hs_n` low at `hcnt` 342..373.
- `h_offs`=-16: `hs_beg`=280. Also run with HS_START=370, `h_offs`=+15: `hs_beg`=16 (400 mod 384) → `hs_n` low at `hcnt` 16..47; line length stays 384.
- `v_offs`=+7 written at `vcnt`=100: current frame keeps vsync at 234..236, next frame moves to 241..243, with no `frame_start` glitch.
- Assert `reset_n`=0 for 1 cycle at `vcnt`=235 while `vs_n`=0:
  - next cycle `vs_n`=1, `hblank`=`vblank`=1, `rgb_out`=0
  - the first `ce_pix` after release starts a new line; `frame_cnt`=0
- `rgb_in`=12'hABC constant, `ce_pix` every 8th cycle:
  - `rgb_out`=ABC only while `de`=1, 0 elsewhere
  - outputs hold between enables; each strobe lasts one `clk_sys` cycle
